// File: rtl/station_pkg.sv
`default_nettype none
// ============================================================================
// Module   : station_pkg
// Purpose  : Shared state encoding, opcodes and widths for the station
//            controller.
// Revision : 1.0 - initial release
// ============================================================================
package station_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_TRANSIT = 2'd1,
        ST_ARRIVE  = 2'd2
    } state_t;

    localparam logic [1:0] OP_STOP = 2'b00;
    localparam logic [1:0] OP_GOTO = 2'b01;

    localparam int TIMER_W = 28;
    localparam int DEST_W  = 6;

    function automatic logic [TIMER_W-1:0] widen_buzz(input logic [23:0] cycles);
        return {{(TIMER_W-24){1'b0}}, cycles};
    endfunction

endpackage
`default_nettype wire

// File: rtl/station_timer.sv
`default_nettype none
// ============================================================================
// Module   : station_timer
// Purpose  : Loadable saturating down-counter; expire is flagged on the last
//            cycle of a loaded interval so the owner leaves on the next edge.
// Revision : 1.0 - initial release
// ============================================================================
module station_timer
    import station_pkg::*;
#(
    parameter int WIDTH = TIMER_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             expire
);

    localparam logic [WIDTH-1:0] c_one  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] c_zero = '0;

    logic [WIDTH-1:0] r_count;

    // A loaded value of N expires on the Nth enabled cycle; zero never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= c_zero;
        end else if (load) begin
            r_count <= load_val;
        end else if (en && (r_count != c_zero)) begin
            r_count <= r_count - c_one;
        end
    end

    assign expire = (r_count <= c_one);

endmodule
`default_nettype wire

// File: rtl/station_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : station_ctrl
// Purpose  : Station-to-station motion controller: accepts STOP/GOTO
//            commands, matches barcode IDs, drives go/buzz and a timeout flag.
// Revision : 1.0 - initial release
// ============================================================================
module station_ctrl
    import station_pkg::*;
#(
    parameter logic [23:0] BUZZ_CYCLES    = 24'd12_500_000,
    parameter logic [27:0] TIMEOUT_CYCLES = 28'd200_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_rdy,
    input  logic [15:0] cmd,
    output logic        clr_cmd_rdy,
    input  logic        ID_vld,
    input  logic [7:0]  ID,
    output logic        clr_ID_vld,
    output logic        go,
    output logic        buzz,
    output logic        in_transit,
    output logic        station_err
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DEST_W-1:0]   r_dest;
    logic [DEST_W-1:0]   w_dest_nxt;

    logic                w_cmd_v;
    logic                w_id_v;
    logic [1:0]          w_opcode;
    logic                w_id_match;

    logic                w_tmr_load;
    logic [TIMER_W-1:0]  w_tmr_val;
    logic                w_tmr_en;
    logic                w_tmr_expire;

    logic                w_err_set;
    logic                w_err_clr;

    logic                w_go_nxt;
    logic                w_buzz_nxt;
    logic                w_in_transit_nxt;
    logic                w_err_nxt;
    logic                w_clr_cmd_nxt;
    logic                w_clr_id_nxt;

    // A request still high during its own acknowledge cycle is the same request.
    assign w_cmd_v    = cmd_rdy & ~clr_cmd_rdy;
    assign w_id_v     = ID_vld  & ~clr_ID_vld;
    assign w_opcode   = cmd[15:14];
    assign w_id_match = (ID[DEST_W-1:0] == r_dest);
    assign w_tmr_en   = (r_state != ST_IDLE);

    station_timer #(
        .WIDTH    (TIMER_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (w_tmr_load),
        .load_val (w_tmr_val),
        .en       (w_tmr_en),
        .expire   (w_tmr_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_dest      <= '0;
            go          <= 1'b0;
            buzz        <= 1'b0;
            in_transit  <= 1'b0;
            station_err <= 1'b0;
            clr_cmd_rdy <= 1'b0;
            clr_ID_vld  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_dest      <= w_dest_nxt;
            go          <= w_go_nxt;
            buzz        <= w_buzz_nxt;
            in_transit  <= w_in_transit_nxt;
            station_err <= w_err_nxt;
            clr_cmd_rdy <= w_clr_cmd_nxt;
            clr_ID_vld  <= w_clr_id_nxt;
        end
    end

    // Autonomous transitions first; a valid command then overrides them, and
    // any ID arriving alongside a command is discarded.
    always_comb begin
        w_state_nxt = r_state;
        w_dest_nxt  = r_dest;
        w_tmr_load  = 1'b0;
        w_tmr_val   = TIMEOUT_CYCLES;
        w_err_set   = 1'b0;
        w_err_clr   = 1'b0;

        case (r_state)
            ST_TRANSIT: begin
                if (w_id_v && !w_cmd_v && w_id_match) begin
                    w_state_nxt = ST_ARRIVE;
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = widen_buzz(BUZZ_CYCLES);
                end else if (w_tmr_expire) begin
                    w_state_nxt = ST_IDLE;
                    w_err_set   = 1'b1;
                end
            end
            ST_ARRIVE: begin
                if (w_tmr_expire) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
            end
        endcase

        if (w_cmd_v) begin
            case (w_opcode)
                OP_STOP: begin
                    w_state_nxt = ST_IDLE;
                    w_tmr_load  = 1'b0;
                    w_err_set   = 1'b0;
                end
                OP_GOTO: begin
                    w_state_nxt = ST_TRANSIT;
                    w_dest_nxt  = cmd[DEST_W-1:0];
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = TIMEOUT_CYCLES;
                    w_err_set   = 1'b0;
                    w_err_clr   = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        w_go_nxt         = (w_state_nxt == ST_TRANSIT);
        w_in_transit_nxt = (w_state_nxt == ST_TRANSIT);
        w_buzz_nxt       = (w_state_nxt == ST_ARRIVE);
        w_clr_cmd_nxt    = w_cmd_v;
        w_clr_id_nxt     = w_id_v;
        w_err_nxt        = station_err;
        if (w_err_set) begin
            w_err_nxt = 1'b1;
        end else if (w_err_clr) begin
            w_err_nxt = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_station_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_station_ctrl
// Purpose  : Directed self-checking bench for station_ctrl (BUZZ=8, TO=100).
// Revision : 1.0 - initial release
// ============================================================================
module tb_station_ctrl;

    localparam logic [23:0] BUZZ_CYCLES    = 24'd8;
    localparam logic [27:0] TIMEOUT_CYCLES = 28'd100;

    logic        clk;
    logic        rst;
    logic        cmd_rdy;
    logic [15:0] cmd;
    logic        clr_cmd_rdy;
    logic        ID_vld;
    logic [7:0]  ID;
    logic        clr_ID_vld;
    logic        go;
    logic        buzz;
    logic        in_transit;
    logic        station_err;

    int total;
    int bad;
    int cnt;

    station_ctrl #(
        .BUZZ_CYCLES    (BUZZ_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_rdy     (cmd_rdy),
        .cmd         (cmd),
        .clr_cmd_rdy (clr_cmd_rdy),
        .ID_vld      (ID_vld),
        .ID          (ID),
        .clr_ID_vld  (clr_ID_vld),
        .go          (go),
        .buzz        (buzz),
        .in_transit  (in_transit),
        .station_err (station_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Packs {clr_cmd_rdy, clr_ID_vld, go, buzz, in_transit, station_err}.
    function automatic logic [31:0] outs();
        return {26'd0, clr_cmd_rdy, clr_ID_vld, go, buzz, in_transit, station_err};
    endfunction

    initial begin
        total   = 0;
        bad     = 0;
        rst     = 1'b1;
        cmd_rdy = 1'b0;
        cmd     = 16'h0000;
        ID_vld  = 1'b0;
        ID      = 8'h00;

        tick();
        check("reset_outs", outs(), 32'h00);
        tick();
        rst = 1'b0;
        tick();
        check("idle_outs", outs(), 32'h00);

        // ID outside TRANSIT: acknowledged, discarded
        ID_vld = 1'b1; ID = 8'h00;
        tick();
        check("idle_id_ack", outs(), 32'h10);
        ID_vld = 1'b0;
        tick();
        check("idle_id_done", outs(), 32'h00);

        // GOTO 5, cmd_rdy held through the acknowledge cycle
        cmd_rdy = 1'b1; cmd = 16'h4005;
        tick();
        check("goto5_ack", outs(), 32'h2A);
        tick();
        check("goto5_no_reack", outs(), 32'h0A);
        cmd_rdy = 1'b0;
        ID_vld = 1'b1; ID = 8'h03;
        tick();
        check("id03_mismatch", outs(), 32'h1A);
        ID_vld = 1'b0;
        tick();
        check("id03_after", outs(), 32'h0A);
        ID_vld = 1'b1; ID = 8'h05;
        tick();
        check("id05_arrive", outs(), 32'h14);
        ID_vld = 1'b0;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (!buzz) break;
            cnt++;
            tick();
        end
        check("buzz_len", cnt, 32'd8);
        check("after_arrive", outs(), 32'h00);

        // GOTO 7 with no ID: times out after 100 cycles
        cmd_rdy = 1'b1; cmd = 16'h4007;
        tick();
        cmd_rdy = 1'b0;
        cnt = 0;
        for (int i = 0; i < 200; i++) begin
            if (!in_transit) break;
            cnt++;
            tick();
        end
        check("timeout_len", cnt, 32'd100);
        check("timeout_outs", outs(), 32'h01);
        cmd_rdy = 1'b1; cmd = 16'h4007;
        tick();
        cmd_rdy = 1'b0;
        check("goto_clr_err", outs(), 32'h2A);

        // STOP mid-transit
        tick();
        cmd_rdy = 1'b1; cmd = 16'h0000;
        tick();
        cmd_rdy = 1'b0;
        check("stop_outs", outs(), 32'h20);
        tick();
        check("stop_single_ack", outs(), 32'h00);

        // GOTO 2 together with ID 02 from IDLE
        cmd_rdy = 1'b1; cmd = 16'h4002;
        ID_vld  = 1'b1; ID  = 8'h02;
        tick();
        cmd_rdy = 1'b0; ID_vld = 1'b0;
        check("cmd_id_same", outs(), 32'h3A);
        tick();
        check("cmd_id_after", outs(), 32'h0A);

        // Opcode 11 in TRANSIT: ack only, dest stays 2
        cmd_rdy = 1'b1; cmd = 16'hC005;
        tick();
        cmd_rdy = 1'b0;
        check("op11_ack", outs(), 32'h2A);
        ID_vld = 1'b1; ID = 8'h05;
        tick();
        ID_vld = 1'b0;
        check("op11_dest_kept", outs(), 32'h1A);
        tick();
        ID_vld = 1'b1; ID = 8'h02;
        tick();
        ID_vld = 1'b0;
        check("dest2_arrive", outs(), 32'h14);
        tick();
        check("arrive_hold", outs(), 32'h04);

        // Asynchronous reset during ARRIVE
        #2 rst = 1'b1;
        #1 check("async_rst", outs(), 32'h00);
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_idle", outs(), 32'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/station_ctrl.md
STATION_CTRL -- requirements
Module: station_ctrl

Interface
REQ-001 Parameter BUZZ_CYCLES, default 24'd12_500_000, buzzer on-time after arrival in clk cycles.
REQ-002 Parameter TIMEOUT_CYCLES, default 28'd200_000_000, maximum TRANSIT duration before error.
REQ-003 Port list: one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  system clock, all logic on rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 cmd_rdy  input  1  level, new command present on cmd.
REQ-007 cmd  input  16  command: [15:14] opcode, [5:0] destination station.
REQ-008 clr_cmd_rdy  output  1  one-cycle pulse acknowledging cmd.
REQ-009 ID_vld  input  1  level, barcode station ID present on ID.
REQ-010 ID  input  8  barcode ID; [5:0] station number.
REQ-011 clr_ID_vld  output  1  one-cycle pulse acknowledging ID.
REQ-012 go  output  1  motion enable to follower.
REQ-013 buzz  output  1  buzzer drive, high during ARRIVE.
REQ-014 in_transit  output  1  high while state is TRANSIT.
REQ-015 station_err  output  1  sticky timeout flag.

Function
REQ-016 Opcodes: 2'b00 STOP, 2'b01 GOTO; 2'b10/2'b11 SHALL be acknowledged and otherwise ignored.
REQ-017 States IDLE, TRANSIT, ARRIVE; all outputs registered; input seen at edge N -> response visible after edge N+1.
REQ-018 Any cmd_rdy sample SHALL produce exactly one clr_cmd_rdy pulse next cycle, in every state; cmd_rdy still high in the pulse cycle SHALL NOT be re-acknowledged.
REQ-019 STOP in any state: go=0, buzz=0, next state IDLE.
REQ-020 GOTO in IDLE or ARRIVE: latch dest=cmd[5:0], go=1, buzz=0, clear station_err, load timeout timer, next TRANSIT.
REQ-021 GOTO in TRANSIT: replace dest, reload timeout timer, remain TRANSIT, go stays 1.
REQ-022 Any ID_vld sample SHALL produce one clr_ID_vld pulse next cycle, in every state; outside TRANSIT the ID is discarded.
REQ-023 TRANSIT with ID_vld and ID[5:0]==dest: go=0, buzz=1, load timer with BUZZ_CYCLES, next ARRIVE.
REQ-024 TRANSIT with ID_vld and ID[5:0]!=dest: stay TRANSIT, go stays 1, timer untouched.
REQ-025 cmd_rdy and ID_vld in same cycle: command processed, ID acknowledged and discarded.
REQ-026 TRANSIT timeout: when timer reaches TIMEOUT_CYCLES-1 without match, go=0, station_err=1, next IDLE; a coincident matching ID wins over timeout.
REQ-027 ARRIVE: after BUZZ_CYCLES cycles buzz=0, next IDLE; go remains 0.
REQ-028 Timer saturates, never wraps; ID[7:6] not checked here (reader qualifies).

Reset
REQ-029 On rst: state IDLE, go=0, buzz=0, in_transit=0, station_err=0, clr_cmd_rdy=0, clr_ID_vld=0, dest=6'h00, timer=0.
REQ-030 Reset mid-TRANSIT or mid-ARRIVE SHALL drop go and buzz immediately (asynchronous).

Structure
REQ-031 Package station_pkg holds state enum typedef and opcode localparams (OP_STOP, OP_GOTO).
REQ-032 One sub-module station_timer (load value, enable, expire flag) instantiated once, shared by buzz and timeout since states are exclusive.

Verification (bench params BUZZ_CYCLES=8, TIMEOUT_CYCLES=100)
REQ-033 GOTO cmd=16'h4005, then ID=8'h03 then ID=8'h05 -> go=1 after one cycle, stays 1 across 03, drops to 0 and buzz=1 one cycle after 05, buzz high 8 cycles, then IDLE.
REQ-034 GOTO 16'h4007, no IDs for 100 cycles -> go=0, station_err=1, IDLE; next GOTO clears station_err.
REQ-035 GOTO 16'h4005 then STOP 16'h0000 mid-transit -> go=0 next cycle, IDLE, one clr_cmd_rdy per command.
REQ-036 cmd_rdy (GOTO 16'h4002) and ID_vld (ID=8'h02) same cycle from IDLE -> TRANSIT with dest 2, ID discarded, both clears pulse once.
REQ-037 Opcode 2'b11 in TRANSIT -> clr_cmd_rdy pulse only, dest/go/timer unchanged.
REQ-038 rst asserted during ARRIVE -> buzz=0, go=0 without clock edge; all outputs at reset values.
